// File: rtl/btn_pkg.sv
// Shared FSM encoding and default timing constants for the
// push-button conditioner.
package btn_pkg;

    localparam int unsigned DEB_CYCLES_DEF  = 540_000;
    localparam int unsigned LONG_CYCLES_DEF = 27_000_000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } btn_state_e;

    function automatic int cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button-side bundle: raw active-low input plus the conditioned
// level and the short/long press strobes.
interface btn_conditioner_if;

    logic btn_n;
    logic btn_level;
    logic press_pulse;
    logic long_pulse;

    modport master (
        output btn_n,
        input  btn_level,
        input  press_pulse,
        input  long_pulse
    );

    modport slave (
        input  btn_n,
        output btn_level,
        output press_pulse,
        output long_pulse
    );

endinterface

// File: rtl/btn_debounce_filter.sv
// Two-flop synchronizer plus debounce counter; stable_o is the
// accepted active-low button level (1 = released).
module btn_debounce_filter
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn_n,
    output logic stable_o
);

    localparam int DW = cnt_width(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Any return to the stable level restarts the qualification window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounced button with short/long press strobes. Long-press
// detection is built only when BTN_LONG_PRESS_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    btn_conditioner_if.slave bus
);

    logic       stable;
    logic       pressed;
    btn_state_e state_q;
    btn_state_e state_d;
    logic       level_q;
    logic       press_q;
    logic       press_d;
    logic       long_q;
    logic       long_d;

    btn_debounce_filter #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_filter (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .btn_n    (bus.btn_n),
        .stable_o (stable)
    );

    assign pressed = ~stable;

`ifdef BTN_LONG_PRESS_EN
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;

    // The long threshold outranks a coincident release.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        press_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESSED;
                    hold_d  = '0;
                end
            end
            ST_PRESSED: begin
                if (hold_q == HOLD_MAX) begin
                    long_d  = 1'b1;
                    state_d = pressed ? ST_LONG_HELD : ST_IDLE;
                end else if (!pressed) begin
                    press_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (!pressed) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) hold_q <= '0;
        else            hold_q <= hold_d;
    end
`else
    logic unused_long;
    assign unused_long = ^LONG_CYCLES;

    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!pressed) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            level_q <= 1'b0;
            press_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= pressed;
            press_q <= press_d;
            long_q  <= long_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.press_pulse = press_q;
    assign bus.long_pulse  = long_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected output events
// (kind, cycle) are queued per scenario and matched against observed ones.
module tb_btn_conditioner;

  localparam int DEB = 8;
  localparam int LNG = 32;
  localparam int LAT = DEB + 3;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_PRESS = 2;
  localparam int K_LONG = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int viol = 0;
  logic lvl_p = 1'b0;
  logic prs_p = 1'b0;
  logic lng_p = 1'b0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  btn_conditioner_if bus();

  btn_conditioner #(
    .DEB_CYCLES(DEB),
    .LONG_CYCLES(LNG)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      lvl_p = 1'b0;
      prs_p = 1'b0;
      lng_p = 1'b0;
    end else begin
      if (bus.btn_level && !lvl_p) obs_q.push_back('{K_RISE, cyc});
      if (!bus.btn_level && lvl_p) obs_q.push_back('{K_FALL, cyc});
      if (bus.press_pulse) obs_q.push_back('{K_PRESS, cyc});
      if (bus.long_pulse) obs_q.push_back('{K_LONG, cyc});
      if (bus.press_pulse && bus.long_pulse) viol++;
      if (bus.press_pulse && prs_p) viol++;
      if (bus.long_pulse && lng_p) viol++;
      lvl_p = bus.btn_level;
      prs_p = bus.press_pulse;
      lng_p = bus.long_pulse;
    end
  end

  task automatic drive_press(input int h, output int d, output int r);
    @(negedge sys_clk);
    d = cyc;
    bus.btn_n = 1'b0;
    repeat (h) @(negedge sys_clk);
    r = cyc;
    bus.btn_n = 1'b1;
    repeat (30) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    n_total++;
    if ({bus.btn_level, bus.press_pulse, bus.long_pulse} !== 3'b000)
      $display("FAIL reset_out: got %b expected 000",
               {bus.btn_level, bus.press_pulse, bus.long_pulse});
    else n_pass++;
    sys_rst_n = 1'b1;
    repeat (15) @(negedge sys_clk);
    n_total++;
    if ({bus.btn_level, bus.press_pulse, bus.long_pulse} !== 3'b000)
      $display("FAIL idle_out: got %b expected 000",
               {bus.btn_level, bus.press_pulse, bus.long_pulse});
    else n_pass++;
    n_total++;
    if (obs_q.size() !== 0)
      $display("FAIL idle_events: got %0d expected 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_short_press();
    int d, r;
    ev_t e, o;
    drive_press(40, d, r);
    exp_q.push_back('{K_RISE, d + LAT});
`ifndef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_PRESS, d + LAT});
`endif
    exp_q.push_back('{K_FALL, r + LAT});
`ifdef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_PRESS, r + LAT});
`endif
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL short_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) begin
        $display("FAIL short_ev: got none expected kind %0d cyc %0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc)
          $display("FAIL short_ev: got kind %0d cyc %0d expected kind %0d cyc %0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        else n_pass++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      bus.btn_n = (i < 30) ? (((i / 3) % 2) != 0) : 1'b1;
      if (bus.btn_level || bus.press_pulse || bus.long_pulse) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL glitch_out: got %0d active cycles expected 0", bad);
    else n_pass++;
    n_total++;
    if (obs_q.size() !== 0)
      $display("FAIL glitch_events: got %0d expected 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_long_press();
    int d, r;
    ev_t e, o;
    drive_press(100, d, r);
    exp_q.push_back('{K_RISE, d + LAT});
`ifdef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_LONG, d + LAT + LNG});
`else
    exp_q.push_back('{K_PRESS, d + LAT});
`endif
    exp_q.push_back('{K_FALL, r + LAT});
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL long_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) begin
        $display("FAIL long_ev: got none expected kind %0d cyc %0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc)
          $display("FAIL long_ev: got kind %0d cyc %0d expected kind %0d cyc %0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        else n_pass++;
      end
    end
    obs_q.delete();
  endtask

  // Release one cycle before, then exactly on, the long threshold,
  // then a short press to show the FSM is back in IDLE.
  task automatic test_long_boundary();
    int d, r;
    ev_t e, o;
    drive_press(LNG - 1, d, r);
    exp_q.push_back('{K_RISE, d + LAT});
`ifdef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_FALL, r + LAT});
    exp_q.push_back('{K_PRESS, r + LAT});
`else
    exp_q.push_back('{K_PRESS, d + LAT});
    exp_q.push_back('{K_FALL, r + LAT});
`endif
    drive_press(LNG, d, r);
    exp_q.push_back('{K_RISE, d + LAT});
`ifdef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_FALL, r + LAT});
    exp_q.push_back('{K_LONG, d + LAT + LNG});
`else
    exp_q.push_back('{K_PRESS, d + LAT});
    exp_q.push_back('{K_FALL, r + LAT});
`endif
    drive_press(12, d, r);
    exp_q.push_back('{K_RISE, d + LAT});
`ifdef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_FALL, r + LAT});
    exp_q.push_back('{K_PRESS, r + LAT});
`else
    exp_q.push_back('{K_PRESS, d + LAT});
    exp_q.push_back('{K_FALL, r + LAT});
`endif
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL bound_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) begin
        $display("FAIL bound_ev: got none expected kind %0d cyc %0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc)
          $display("FAIL bound_ev: got kind %0d cyc %0d expected kind %0d cyc %0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        else n_pass++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_press();
    int d, x, r;
    ev_t e, o;
    @(negedge sys_clk);
    d = cyc;
    bus.btn_n = 1'b0;
    exp_q.push_back('{K_RISE, d + LAT});
`ifndef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_PRESS, d + LAT});
`endif
    repeat (20) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.btn_level, bus.press_pulse, bus.long_pulse} !== 3'b000)
      $display("FAIL rst_mid_assert: got %b expected 000",
               {bus.btn_level, bus.press_pulse, bus.long_pulse});
    else n_pass++;
    repeat (2) @(negedge sys_clk);
    n_total++;
    if ({bus.btn_level, bus.press_pulse, bus.long_pulse} !== 3'b000)
      $display("FAIL rst_mid_hold: got %b expected 000",
               {bus.btn_level, bus.press_pulse, bus.long_pulse});
    else n_pass++;
    x = cyc;
    sys_rst_n = 1'b1;
    exp_q.push_back('{K_RISE, x + LAT});
`ifndef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_PRESS, x + LAT});
`endif
    repeat (30) @(negedge sys_clk);
    r = cyc;
    bus.btn_n = 1'b1;
    exp_q.push_back('{K_FALL, r + LAT});
`ifdef BTN_LONG_PRESS_EN
    exp_q.push_back('{K_PRESS, r + LAT});
`endif
    repeat (30) @(negedge sys_clk);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL rst_mid_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) begin
        $display("FAIL rst_mid_ev: got none expected kind %0d cyc %0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc)
          $display("FAIL rst_mid_ev: got kind %0d cyc %0d expected kind %0d cyc %0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        else n_pass++;
      end
    end
    obs_q.delete();
  endtask

  initial begin
    bus.btn_n = 1'b1;
    test_reset();
    test_short_press();
    test_glitch();
    test_long_press();
    test_long_boundary();
    test_reset_mid_press();
    n_total++;
    if (viol !== 0)
      $display("FAIL pulse_rules: got %0d overlapping/repeated strobes expected 0", viol);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
